// File: rtl/sccb_slave_if.sv
// rtl/sccb_slave_if.sv - SCCB pin and register-port bundle for the sccb_slave target
interface sccb_slave_if;
    logic       sccb_e;
    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdat;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdat;
    logic       busy;
    logic       id_miss;

    modport slave (
        input  sccb_e, scl_in, sda_in, reg_rdat,
        output sda_out, sda_oe, reg_addr, reg_wdat, reg_we, reg_re, busy, id_miss
    );

    modport master (
        output sccb_e, scl_in, sda_in, reg_rdat,
        input  sda_out, sda_oe, reg_addr, reg_wdat, reg_we, reg_re, busy, id_miss
    );
endinterface

// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - oversampled SCCB target mapping bus transactions onto a register port
module sccb_slave #(
    parameter logic [6:0] DEV_ID = 7'h48,
    parameter bit         ACK_EN = 1'b1
) (
    input  logic        sys_clk,
    input  logic        rst,
    sccb_slave_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X,
        S_WDAT, S_WDAT_X, S_RDAT, S_RDAT_X, S_IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_dl_q, scl_dl_d;
    logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_dl_q, sda_dl_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rd_q, rd_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdat_q, reg_wdat_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       sda_oe_q, sda_oe_d;
    logic       sda_out_q, sda_out_d;
    logic       id_miss_q, id_miss_d;
    logic [7:0] byte_in;

    // Bus events on the synchronized pins; START/STOP need scl high on both samples.
    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_rise  = scl_s2_q & ~scl_dl_q;
    assign scl_fall  = ~scl_s2_q & scl_dl_q;
    assign bus_start = scl_s2_q & scl_dl_q & sda_dl_q & ~sda_s2_q;
    assign bus_stop  = scl_s2_q & scl_dl_q & ~sda_dl_q & sda_s2_q;

    // State register; synchronizers reset to the idle-high bus level to avoid a false START.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_dl_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_dl_q   <= 1'b1;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rd_q       <= 1'b0;
            reg_addr_q <= 8'h00;
            reg_wdat_q <= 8'h00;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            sda_out_q  <= 1'b0;
            id_miss_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            scl_dl_q   <= scl_dl_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            sda_dl_q   <= sda_dl_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rd_q       <= rd_d;
            reg_addr_q <= reg_addr_d;
            reg_wdat_q <= reg_wdat_d;
            reg_we_q   <= reg_we_d;
            reg_re_q   <= reg_re_d;
            sda_oe_q   <= sda_oe_d;
            sda_out_q  <= sda_out_d;
            id_miss_q  <= id_miss_d;
        end
    end

    // Next-state: abort conditions first, then sda drive on scl falls, bit sampling on scl rises.
    always_comb begin
        state_d    = state_q;
        scl_s1_d   = bus.scl_in;
        scl_s2_d   = scl_s1_q;
        scl_dl_d   = scl_s2_q;
        sda_s1_d   = bus.sda_in;
        sda_s2_d   = sda_s1_q;
        sda_dl_d   = sda_s2_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rd_d       = rd_q;
        reg_addr_d = reg_addr_q;
        reg_wdat_d = reg_wdat_q;
        reg_we_d   = 1'b0;
        reg_re_d   = 1'b0;
        sda_oe_d   = sda_oe_q;
        sda_out_d  = sda_out_q;
        id_miss_d  = 1'b0;
        byte_in    = {shift_q[6:0], sda_s2_q};

        // Read data arrives one cycle after the strobe.
        if (reg_re_q) begin
            shift_d = bus.reg_rdat;
        end
        // Post-increment the pointer once the write strobe has been seen with the old address.
        if (reg_we_q && (state_q == S_WDAT_X)) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (bus.sccb_e || bus_stop) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            sda_out_d = 1'b0;
        end else if (bus_start) begin
            state_d   = S_ID;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            sda_out_d = 1'b0;
        end else begin
            if (scl_fall) begin
                sda_oe_d  = 1'b0;
                sda_out_d = 1'b0;
                case (state_q)
                    S_ID_X:            sda_oe_d = ACK_EN && !rd_q;
                    S_SUB_X, S_WDAT_X: sda_oe_d = ACK_EN;
                    S_RDAT: begin
                        sda_oe_d  = 1'b1;
                        sda_out_d = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                    end
                    default: ;
                endcase
            end
            if (scl_rise) begin
                case (state_q)
                    S_ID, S_SUB, S_WDAT: begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == S_ID) begin
                                if (byte_in[7:1] != DEV_ID) begin
                                    id_miss_d = 1'b1;
                                    state_d   = S_IGNORE;
                                end else begin
                                    rd_d    = byte_in[0];
                                    state_d = S_ID_X;
                                end
                            end else if (state_q == S_SUB) begin
                                reg_addr_d = byte_in;
                                state_d    = S_SUB_X;
                            end else begin
                                reg_wdat_d = byte_in;
                                reg_we_d   = 1'b1;
                                state_d    = S_WDAT_X;
                            end
                        end
                    end
                    S_ID_X: begin
                        if (rd_q) begin
                            reg_re_d  = 1'b1;
                            bit_cnt_d = 3'd0;
                            state_d   = S_RDAT;
                        end else begin
                            state_d = S_SUB;
                        end
                    end
                    S_SUB_X, S_WDAT_X: state_d = S_WDAT;
                    S_RDAT: begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_RDAT_X;
                        end
                    end
                    S_RDAT_X: begin
                        if (!sda_s2_q) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            reg_re_d   = 1'b1;
                            bit_cnt_d  = 3'd0;
                            state_d    = S_RDAT;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_out  = sda_out_q;
    assign bus.sda_oe   = sda_oe_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.reg_wdat = reg_wdat_q;
    assign bus.reg_we   = reg_we_q;
    assign bus.reg_re   = reg_re_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.id_miss  = id_miss_q;
endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - scoreboard bench driving SCCB transactions into sccb_slave
module tb_sccb_slave;
    localparam int H = 8;

    logic sys_clk;
    logic rst;
    logic m_sda;
    int   checks;
    int   errors;
    int   miss_cnt;
    int   oe_cnt;
    int   viol_cnt;
    logic [7:0]  mem [256];
    logic [15:0] exp_wr[$];
    logic [15:0] obs_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  obs_rd[$];

    sccb_slave_if bus ();

    sccb_slave #(.DEV_ID(7'h48), .ACK_EN(1'b1)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    // Open-drain line: either side can pull low.
    assign bus.sda_in = m_sda & (bus.sda_oe ? bus.sda_out : 1'b1);

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Monitor away from the active edge; serves read data for exactly the cycle after reg_re.
    always @(negedge sys_clk) begin
        if (bus.reg_we) obs_wr.push_back({bus.reg_addr, bus.reg_wdat});
        if (bus.reg_re) begin
            obs_rd.push_back(bus.reg_addr);
            bus.reg_rdat = mem[bus.reg_addr];
        end else begin
            bus.reg_rdat = 8'hEE;
        end
        if (bus.id_miss) miss_cnt++;
        if (bus.sda_oe) oe_cnt++;
        if ((bus.reg_we && bus.reg_re) || ((bus.reg_we || bus.reg_re) && !bus.busy)) viol_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic m_bit(input logic b, output logic line, output logic oe);
        m_sda = b;
        cyc(H);
        bus.scl_in = 1'b1;
        cyc(H);
        line = bus.sda_in;
        oe   = bus.sda_oe;
        bus.scl_in = 1'b0;
        cyc(2);
    endtask

    task automatic m_start;
        m_sda = 1'b1;
        cyc(H);
        bus.scl_in = 1'b1;
        cyc(H);
        m_sda = 1'b0;
        cyc(H);
        bus.scl_in = 1'b0;
        cyc(H);
    endtask

    task automatic m_stop;
        m_sda = 1'b0;
        cyc(H);
        bus.scl_in = 1'b1;
        cyc(H);
        m_sda = 1'b1;
        cyc(H);
    endtask

    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        logic l, o;
        for (int i = 7; i >= 0; i--) m_bit(b[i], l, o);
        m_bit(1'b1, ack, o);
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] d, output logic [7:0] oes, output logic x_oe);
        logic l;
        for (int i = 7; i >= 0; i--) m_bit(1'b1, d[i], oes[i]);
        m_bit(nack, l, x_oe);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cyc(5);
        checks++;
        if ({bus.sda_oe, bus.sda_out, bus.reg_we, bus.reg_re, bus.busy, bus.id_miss} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {bus.sda_oe, bus.sda_out, bus.reg_we, bus.reg_re, bus.busy, bus.id_miss});
        end
        checks++;
        if ({bus.reg_addr, bus.reg_wdat} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs got %h want 0000", {bus.reg_addr, bus.reg_wdat});
        end
        rst = 1'b1;
        cyc(H);
    endtask

    task automatic test_write3;
        logic a0, a1, a2;
        m_start;
        m_wbyte(8'h90, a0);
        m_wbyte(8'h12, a1);
        exp_wr.push_back({8'h12, 8'hA5});
        m_wbyte(8'hA5, a2);
        m_stop;
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL w3_acks got %b want 000", {a0, a1, a2}); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL w3_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.reg_addr !== 8'h13) begin errors++; $display("FAIL w3_addr got %h want 13", bus.reg_addr); end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL w3_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [15:0] e, a;
            e = exp_wr.pop_front(); a = obs_wr.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL w3_wr got %h want %h", a, e); end
        end
        exp_wr.delete(); obs_wr.delete();
    endtask

    task automatic test_ptr_read;
        logic a0, a1, a2, x_oe;
        logic [7:0] d, oes;
        mem[8'h3C] = 8'h5A;
        m_start;
        m_wbyte(8'h90, a0);
        m_wbyte(8'h3C, a1);
        m_stop;
        checks++;
        if (obs_wr.size() != 0) begin errors++; $display("FAIL pr_no_write got %0d want 0", obs_wr.size()); end
        m_start;
        exp_rd.push_back(8'h3C);
        m_wbyte(8'h91, a2);
        m_rbyte(1'b1, d, oes, x_oe);
        m_stop;
        checks++;
        if ({a0, a1, a2} !== 3'b001) begin errors++; $display("FAIL pr_acks got %b want 001", {a0, a1, a2}); end
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL pr_data got %h want 5a", d); end
        checks++;
        if (oes !== 8'hFF || x_oe !== 1'b0) begin errors++; $display("FAIL pr_oe got %h/%b want ff/0", oes, x_oe); end
        checks++;
        if (obs_rd.size() != exp_rd.size()) begin errors++; $display("FAIL pr_rd_count got %0d want %0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            logic [7:0] e, a;
            e = exp_rd.pop_front(); a = obs_rd.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL pr_rd_addr got %h want %h", a, e); end
        end
        exp_rd.delete(); obs_rd.delete(); obs_wr.delete();
    endtask

    task automatic test_id_miss;
        logic a0, a1, a2, a3;
        int m0, o0;
        m0 = miss_cnt; o0 = oe_cnt;
        m_start;
        m_wbyte(8'h84, a0);
        m_wbyte(8'h12, a1);
        m_wbyte(8'h34, a2);
        m_wbyte(8'h56, a3);
        m_stop;
        checks++;
        if (miss_cnt - m0 != 1) begin errors++; $display("FAIL miss_pulses got %0d want 1", miss_cnt - m0); end
        checks++;
        if (oe_cnt - o0 != 0 || {a0, a1, a2, a3} !== 4'b1111) begin
            errors++; $display("FAIL miss_oe got %0d/%b want 0/1111", oe_cnt - o0, {a0, a1, a2, a3});
        end
        checks++;
        if (obs_wr.size() + obs_rd.size() != 0) begin
            errors++; $display("FAIL miss_strobes got %0d want 0", obs_wr.size() + obs_rd.size());
        end
        obs_wr.delete(); obs_rd.delete();
    endtask

    task automatic test_seq_write;
        logic a;
        m_start;
        m_wbyte(8'h90, a);
        m_wbyte(8'hFF, a);
        exp_wr.push_back({8'hFF, 8'h11});
        m_wbyte(8'h11, a);
        exp_wr.push_back({8'h00, 8'h22});
        m_wbyte(8'h22, a);
        m_stop;
        checks++;
        if (bus.reg_addr !== 8'h01) begin errors++; $display("FAIL sw_addr got %h want 01", bus.reg_addr); end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL sw_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [15:0] e, o;
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sw_wr got %h want %h", o, e); end
        end
        exp_wr.delete(); obs_wr.delete();
    endtask

    task automatic test_seq_read;
        logic a, x0, x1;
        logic [7:0] d0, d1, o0, o1;
        mem[8'h10] = 8'hC3;
        mem[8'h11] = 8'h3E;
        m_start;
        m_wbyte(8'h90, a);
        m_wbyte(8'h10, a);
        m_stop;
        m_start;
        exp_rd.push_back(8'h10);
        m_wbyte(8'h91, a);
        exp_rd.push_back(8'h11);
        m_rbyte(1'b0, d0, o0, x0);
        m_rbyte(1'b1, d1, o1, x1);
        m_stop;
        checks++;
        if ({d0, d1} !== 16'hC33E) begin errors++; $display("FAIL sr_data got %h want c33e", {d0, d1}); end
        checks++;
        if ({o0, o1, x0, x1} !== 18'h3FFFC) begin errors++; $display("FAIL sr_oe got %h want 3fffc", {o0, o1, x0, x1}); end
        checks++;
        if (obs_rd.size() != exp_rd.size()) begin errors++; $display("FAIL sr_rd_count got %0d want %0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            logic [7:0] e, o;
            e = exp_rd.pop_front(); o = obs_rd.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sr_rd_addr got %h want %h", o, e); end
        end
        exp_rd.delete(); obs_rd.delete(); obs_wr.delete();
    endtask

    task automatic test_abort_rst;
        logic a, l, o;
        mem[8'h20] = 8'h96;
        m_start;
        m_wbyte(8'h90, a);
        m_wbyte(8'h20, a);
        m_stop;
        m_start;
        m_wbyte(8'h91, a);
        for (int i = 0; i < 3; i++) m_bit(1'b1, l, o);
        m_sda = 1'b1;
        cyc(H);
        checks++;
        if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL ar_driving got %b want 1", bus.sda_oe); end
        bus.scl_in = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        checks++;
        if ({bus.sda_oe, bus.busy, bus.reg_addr} !== 10'h000) begin
            errors++; $display("FAIL ar_after_rst got %h want 000", {bus.sda_oe, bus.busy, bus.reg_addr});
        end
        cyc(3);
        rst = 1'b1;
        cyc(H);
        checks++;
        if (obs_rd.size() != 1 || obs_rd[0] !== 8'h20) begin
            errors++; $display("FAIL ar_reads got %0d want 1 at 20", obs_rd.size());
        end
        obs_rd.delete(); obs_wr.delete();
    endtask

    task automatic test_restart;
        logic a0, a1, a2, a3, a4;
        m_start;
        m_wbyte(8'h90, a0);
        m_wbyte(8'h33, a1);
        m_start;
        m_wbyte(8'h90, a2);
        m_wbyte(8'h44, a3);
        exp_wr.push_back({8'h44, 8'h77});
        m_wbyte(8'h77, a4);
        m_stop;
        checks++;
        if ({a0, a1, a2, a3, a4} !== 5'b0) begin errors++; $display("FAIL rs_acks got %b want 00000", {a0, a1, a2, a3, a4}); end
        checks++;
        if (bus.reg_addr !== 8'h45) begin errors++; $display("FAIL rs_addr got %h want 45", bus.reg_addr); end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rs_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [15:0] e, o;
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rs_wr got %h want %h", o, e); end
        end
        exp_wr.delete(); obs_wr.delete();
    endtask

    task automatic test_sccb_e;
        logic a, l, o;
        m_start;
        m_wbyte(8'h90, a);
        m_wbyte(8'h50, a);
        for (int i = 0; i < 4; i++) m_bit(1'b1, l, o);
        bus.sccb_e = 1'b1;
        cyc(2);
        checks++;
        if ({bus.busy, bus.sda_oe} !== 2'b00) begin errors++; $display("FAIL se_idle got %b want 00", {bus.busy, bus.sda_oe}); end
        m_sda = 1'b1;
        cyc(2);
        bus.scl_in = 1'b1;
        cyc(H);
        bus.sccb_e = 1'b0;
        cyc(H);
        checks++;
        if (obs_wr.size() != 0 || bus.reg_addr !== 8'h50) begin
            errors++; $display("FAIL se_no_write got %0d/%h want 0/50", obs_wr.size(), bus.reg_addr);
        end
        obs_wr.delete(); obs_rd.delete();
    endtask

    initial begin
        checks = 0; errors = 0; miss_cnt = 0; oe_cnt = 0; viol_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA7;
        rst = 1'b0;
        m_sda = 1'b1;
        bus.scl_in = 1'b1;
        bus.sccb_e = 1'b0;
        test_reset;
        test_write3;
        test_ptr_read;
        test_id_miss;
        test_seq_write;
        test_seq_read;
        test_abort_rst;
        test_restart;
        test_sccb_e;
        checks++;
        if (viol_cnt != 0) begin errors++; $display("FAIL strobe_rules got %0d want 0", viol_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
SCCB responder (camera-side target) that decodes SCCB transactions from an SCCB master on scl/sda and maps them onto a simple synchronous register-port interface.
Used as a bus-functional sensor model in simulation and as an on-chip configuration target.
Supports 3-phase write, 2-phase write (address pointer set), and 2-phase read with optional sequential read/write.
All bus inputs are oversampled on sys_clk. No logic runs on the scl clock.

Parameters:
DEV_ID, 7'h48, 7-bit device address. Write ID is 0x90, read ID is 0x91.
ACK_EN, 1, 1: drive sda low during the 9th (X) bit of matched write phases. 0: leave the X bit undriven.

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous reset, active-low
sccb_e  in  1  active-low bus enable; high forces IDLE and releases sda
scl_in  in  1  SCCB clock pin (asynchronous)
sda_in  in  1  SCCB data pin (asynchronous)
sda_out  out  1  value driven on sda when sda_oe=1
sda_oe  out  1  sda drive enable (top level builds the tri-state)
reg_addr  out  8  register address pointer
reg_wdat  out  8  write data, valid while reg_we=1
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdat  in  8  read data, sampled exactly 1 cycle after reg_re
busy  out  1  1 while the FSM is not in IDLE
id_miss  out  1  one-cycle pulse on device-ID mismatch

Behaviour:
- Reset (rst=0 at a sys_clk edge): all outputs 0, reg_addr=0, FSM=IDLE, bit counter=0.
- Input conditioning: 2-flop synchronizers on scl and sda, plus 1 delay stage for edge detection.
- Bus timing requirement: scl high and low times must each be ≥4 sys_clk cycles.
- Bus events (evaluated on synchronized signals):
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Bits are sampled on the scl rising edge, MSB first.
  - sda_out/sda_oe change only on the cycle after a detected scl falling edge.
- FSM states: IDLE, ID, ID_X, SUB, SUB_X, WDAT, WDAT_X, RDAT, RDAT_X, IGNORE.
- Transitions:
  - START from any state → ID, bit counter cleared. reg_addr is kept, so a repeated start is legal.
  - STOP from any state → IDLE, sda_oe=0 on the next cycle.
  - sccb_e=1 → IDLE and sda_oe=0, same as STOP.
  - ID, after 8 bits:
    - ID[7:1]≠DEV_ID → pulse id_miss, go to IGNORE. IGNORE never drives sda; it exits only on START or STOP.
    - ID[0]=0 → ID_X, then SUB.
    - ID[0]=1 → ID_X; reg_re pulses on the cycle after the X-bit rising edge; then RDAT.
  - SUB, after 8 bits: reg_addr ← byte → SUB_X → WDAT. A STOP here completes a 2-phase write (pointer set only).
  - WDAT, after 8 bits: on the cycle after the 8th rising edge, reg_wdat ← byte and reg_we=1 for 1 cycle, using the current reg_addr → WDAT_X.
  - WDAT_X: reg_addr increments (8-bit wrap, 0xFF→0x00) one cycle after reg_we. Further bytes before STOP write sequentially.
  - RDAT: reg_rdat is loaded into the shift register 1 cycle after reg_re. Bit 7 is driven after the first scl falling edge; each later falling edge shifts to the next bit. After 8 bits → RDAT_X.
  - RDAT_X: sda_oe=0 at the falling edge that begins the 9th bit. Master's bit sampled on the rising edge:
    - 0 (ACK) → reg_addr+1 (wrap), reg_re pulse, RDAT.
    - 1 (NA) → IGNORE, wait for STOP.
- X-bit drive (write phases, ACK_EN=1): sda_oe=1 and sda_out=0 from the falling edge after bit 8 until the next falling edge, in ID_X (write ID only), SUB_X and WDAT_X. In ID_X for a read ID, sda is not driven.
- Simultaneous events: START/STOP take priority over bit sampling in the same cycle. A partial byte is discarded and no reg_we is issued.
- reg_we and reg_re are never asserted in the same cycle. Neither is ever asserted in IDLE or IGNORE.
- busy=1 in every state except IDLE.

Test Plan:
- 3-phase write, bytes 0x90, 0x12, 0xA5, then STOP → exactly one reg_we, with reg_addr=0x12 and reg_wdat=0xA5. sda is driven low in all three X bits. busy returns to 0 after STOP.
- 2-phase write 0x90, 0x3C, STOP; then START, 0x91 with reg_rdat=0x5A; master sends NA → one reg_re with reg_addr=0x3C. Bits 0,1,0,1,1,0,1,0 appear on sda_out while sda_oe=1. sda is released at the 9th bit and no second reg_re occurs.
- ID 0x42 then 3 bytes then STOP → one id_miss pulse. sda_oe, reg_we and reg_re stay 0 throughout.
- Sequential write 0x90, 0xFF, 0x11, 0x22 → writes (0xFF, 0x11) then (0x00, 0x22). Final reg_addr=0x01.
- Read 0x91 at pointer 0x10 with master ACK after byte 1, then NA → reg_re at 0x10 and 0x11, two bytes shifted out.
- Abort cases, each checked separately:
  - rst=0 during the 4th bit of RDAT → next cycle sda_oe=0, reg_addr=0, busy=0.
  - Repeated START after the sub-address → ID is re-parsed with no spurious reg_we.
  - sccb_e=1 mid-write → IDLE, with no write for the partial byte.
